nco_cfg_arbiter: RTL and testbench

NCO_CFG_ARBITER -- requirements
Module: nco_cfg_arbiter

---
 rtl/nco_cfg_arbiter.sv | 151 +++++++++++++++
 tb/tb_nco_cfg_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_cfg_arbiter.sv
// Two-requester round-robin arbiter in front of a single NCO configuration port.
// One transaction at a time: grant, strobe configCtl, await ACK/Done (with timeout), respond.
module nco_cfg_arbiter #(
    parameter int unsigned FRE_MOD_WIDTH    = 32,
    parameter int unsigned PHA_MOD_WIDTH    = 32,
    parameter int unsigned CONFIT_CTL_WIDTH = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [2*CONFIT_CTL_WIDTH-1:0] req_ctl,
    input  logic [2*FRE_MOD_WIDTH-1:0]    req_freq,
    input  logic [2*PHA_MOD_WIDTH-1:0]    req_pha,
    output logic [1:0]                    req_done,
    output logic [1:0]                    req_err,
    output logic [FRE_MOD_WIDTH-1:0]      configFreqMod,
    output logic [PHA_MOD_WIDTH-1:0]      configPhasMod,
    output logic [CONFIT_CTL_WIDTH-1:0]   configCtl,
    input  logic                          isConfigACK,
    input  logic                          isConfigDone,
    output logic                          busy,
    output logic                          grant_id
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitAck, StWaitDone, StResp} state_e;

    state_e                        r_state, w_next;
    logic   [CNT_W-1:0]            r_cnt;
    logic                          r_last;
    logic                          r_grant;
    logic                          r_err;
    logic   [CONFIT_CTL_WIDTH-1:0] r_ctl;
    logic   [FRE_MOD_WIDTH-1:0]    r_freq;
    logic   [PHA_MOD_WIDTH-1:0]    r_pha;
    logic                          w_win;
    logic                          w_hs;
    logic                          w_fail;
    logic                          w_timeout;

    // On a tie the requester not granted last wins; a lone request wins outright.
    assign w_win     = (req_valid == 2'b11) ? ~r_last : req_valid[1];
    assign w_hs      = (r_state == StIdle) && (req_valid != 2'b00);
    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_hs) w_next = StIssue;
            end
            StIssue: begin
                if (r_ctl == '0) begin
                    w_next = StResp;
                    w_fail = 1'b1;
                end else begin
                    w_next = StWaitAck;
                end
            end
            StWaitAck: begin
                if (isConfigACK && isConfigDone) begin
                    w_next = StResp;
                end else if (isConfigACK) begin
                    w_next = StWaitDone;
                end else if (w_timeout) begin
                    w_next = StResp;
                    w_fail = 1'b1;
                end
            end
            StWaitDone: begin
                if (isConfigDone) begin
                    w_next = StResp;
                end else if (w_timeout) begin
                    w_next = StResp;
                    w_fail = 1'b1;
                end
            end
            StResp:  w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        req_done  = 2'b00;
        req_err   = 2'b00;
        configCtl = '0;
        busy      = (r_state != StIdle);
        grant_id  = r_grant;
        case (r_state)
            StIdle: begin
                if (req_valid != 2'b00) req_ready[w_win] = 1'b1;
            end
            StIssue: configCtl = r_ctl;
            StResp: begin
                req_done[r_grant] = 1'b1;
                req_err[r_grant]  = r_err;
            end
            default: ;
        endcase
    end

    // Handshake is the ISSUE entry, so the NCO words are the holding registers themselves.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_err   <= 1'b0;
            r_ctl   <= '0;
            r_freq  <= '0;
            r_pha   <= '0;
        end else begin
            if (w_hs) begin
                r_grant <= w_win;
                r_last  <= w_win;
                r_ctl   <= w_win ? req_ctl[2*CONFIT_CTL_WIDTH-1:CONFIT_CTL_WIDTH]
                                 : req_ctl[CONFIT_CTL_WIDTH-1:0];
                r_freq  <= w_win ? req_freq[2*FRE_MOD_WIDTH-1:FRE_MOD_WIDTH]
                                 : req_freq[FRE_MOD_WIDTH-1:0];
                r_pha   <= w_win ? req_pha[2*PHA_MOD_WIDTH-1:PHA_MOD_WIDTH]
                                 : req_pha[PHA_MOD_WIDTH-1:0];
            end
            if (w_next == StResp && r_state != StResp) begin
                r_err <= w_fail;
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == StWaitAck || r_state == StWaitDone) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign configFreqMod = r_freq;
    assign configPhasMod = r_pha;

endmodule

// File: tb/tb_nco_cfg_arbiter.sv
// Bench for nco_cfg_arbiter: hand-computed vector table, reset-abort sequence,
// then randomized transactions checked against a transaction-level timing model.
module tb_nco_cfg_arbiter;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_ctl;
    logic [63:0] req_freq;
    logic [63:0] req_pha;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [31:0] configFreqMod;
    logic [31:0] configPhasMod;
    logic [3:0]  configCtl;
    logic        isConfigACK;
    logic        isConfigDone;
    logic        busy;
    logic        grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_gid;

    nco_cfg_arbiter #(
        .FRE_MOD_WIDTH   (32),
        .PHA_MOD_WIDTH   (32),
        .CONFIT_CTL_WIDTH(4),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_ctl      (req_ctl),
        .req_freq     (req_freq),
        .req_pha      (req_pha),
        .req_done     (req_done),
        .req_err      (req_err),
        .configFreqMod(configFreqMod),
        .configPhasMod(configPhasMod),
        .configCtl    (configCtl),
        .isConfigACK  (isConfigACK),
        .isConfigDone (isConfigDone),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] valid;
        logic [3:0] c0;
        logic [3:0] c1;
        int         ack;
        int         done;
        logic       gid;
        int         k;
        logic       err;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    // Completion offset (cycles after handshake) and error flag, from the protocol rules.
    task automatic model(input logic [3:0] ctl, input int a, input int d,
                         output int k, output logic e);
        if (ctl == 4'h0) begin
            k = 2; e = 1'b1;
        end else if (a >= 2 && a <= 1 + TO) begin
            if (d == a) begin
                k = a + 1; e = 1'b0;
            end else if (d >= a + 1 && d <= a + TO) begin
                k = d + 1; e = 1'b0;
            end else begin
                k = a + 1 + TO; e = 1'b1;
            end
        end else begin
            k = 2 + TO; e = 1'b1;
        end
    endtask

    task automatic run_txn(input logic [1:0] valid, input logic [3:0] c0, input logic [3:0] c1,
                           input logic [31:0] f0, input logic [31:0] f1,
                           input logic [31:0] p0, input logic [31:0] p1,
                           input int ack_off, input int done_off,
                           input logic gid, input int exp_k, input logic exp_err);
        logic [3:0]  cw;
        logic [31:0] fw;
        logic [31:0] pw;
        cw = gid ? c1 : c0;
        fw = gid ? f1 : f0;
        pw = gid ? p1 : p0;
        req_valid = valid;
        req_ctl   = {c1, c0};
        req_freq  = {f1, f0};
        req_pha   = {p1, p0};
        @(negedge CLK);
        check("idle_busy", 64'(busy), 64'(1'b0));
        check("idle_ready", 64'(req_ready), 64'(oh(gid)));
        for (int k = 1; k <= exp_k; k++) begin
            @(posedge CLK);
            #1;
            isConfigACK  = (k == ack_off);
            isConfigDone = (k == done_off);
            @(negedge CLK);
            check("cfg_ctl", 64'(configCtl), 64'((k == 1) ? cw : 4'h0));
            check("done", 64'(req_done), 64'((k == exp_k) ? oh(gid) : 2'b00));
            check("err", 64'(req_err), 64'((k == exp_k && exp_err) ? oh(gid) : 2'b00));
            check("busy", 64'(busy), 64'(1'b1));
            check("ready_busy", 64'(req_ready), 64'(2'b00));
            check("grant_id", 64'(grant_id), 64'(gid));
            check("freq", 64'(configFreqMod), 64'(fw));
            check("pha", 64'(configPhasMod), 64'(pw));
        end
        @(posedge CLK);
        #1;
        isConfigACK  = 1'b0;
        isConfigDone = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'(2'b00));
        check({tag, "_done"}, 64'(req_done), 64'(2'b00));
        check({tag, "_err"}, 64'(req_err), 64'(2'b00));
        check({tag, "_ctl"}, 64'(configCtl), 64'(4'h0));
        check({tag, "_freq"}, 64'(configFreqMod), 64'(32'h0));
        check({tag, "_pha"}, 64'(configPhasMod), 64'(32'h0));
        check({tag, "_busy"}, 64'(busy), 64'(1'b0));
        check({tag, "_gid"}, 64'(grant_id), 64'(1'b0));
    endtask

    initial begin
        // valid, c0, c1, ack, done, gid, k, err  (ack/done 0 = never)
        tbl[0]  = '{2'b11, 4'h1, 4'h2, 2, 3, 1'b0, 4, 1'b0};
        tbl[1]  = '{2'b11, 4'h1, 4'h2, 2, 2, 1'b1, 3, 1'b0};
        tbl[2]  = '{2'b11, 4'h4, 4'h8, 3, 4, 1'b0, 5, 1'b0};
        tbl[3]  = '{2'b01, 4'h1, 4'h0, 3, 5, 1'b0, 6, 1'b0};
        tbl[4]  = '{2'b10, 4'h0, 4'h2, 0, 0, 1'b1, 18, 1'b1};
        tbl[5]  = '{2'b01, 4'h0, 4'h3, 2, 3, 1'b0, 2, 1'b1};
        tbl[6]  = '{2'b10, 4'h0, 4'h8, 4, 4, 1'b1, 5, 1'b0};
        tbl[7]  = '{2'b01, 4'h3, 4'h0, 2, 0, 1'b0, 19, 1'b1};
        tbl[8]  = '{2'b10, 4'h0, 4'h4, 17, 18, 1'b1, 19, 1'b0};
        tbl[9]  = '{2'b11, 4'h5, 4'h1, 1, 3, 1'b0, 18, 1'b1};
        tbl[10] = '{2'b11, 4'h1, 4'h6, 5, 3, 1'b1, 22, 1'b1};
        tbl[11] = '{2'b01, 4'h1, 4'h0, 2, 18, 1'b0, 19, 1'b0};

        RST = 1'b1;
        req_valid = 2'b00;
        req_ctl = '0;
        req_freq = '0;
        req_pha = '0;
        isConfigACK = 1'b0;
        isConfigDone = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_state("rst");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].valid, tbl[i].c0, tbl[i].c1,
                    32'h0CCC_CCCC + 32'(i), 32'hA000_0000 + 32'(i),
                    32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i),
                    tbl[i].ack, tbl[i].done, tbl[i].gid, tbl[i].k, tbl[i].err);
        end

        // Abort in WAIT_DONE: no completion pulse, everything back to reset values.
        req_valid = 2'b01;
        req_ctl   = 8'h01;
        req_freq  = 64'h0000_0000_1234_5678;
        req_pha   = 64'h0000_0000_0000_0042;
        @(negedge CLK);
        check("abort_ready", 64'(req_ready), 64'(2'b01));
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK);
            #1;
            isConfigACK = (k == 2);
            if (k == 4) begin
                RST = 1'b1;
                req_valid = 2'b00;
            end
            @(negedge CLK);
            check("abort_nodone", 64'(req_done), 64'(2'b00));
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check_reset_state("abort");
        @(posedge CLK);
        #1;
        run_txn(2'b11, 4'h2, 4'h1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h5, 32'h6,
                2, 4, 1'b0, 5, 1'b0);
        last_gid = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  v;
            logic [3:0]  c0, c1, cw;
            logic [31:0] f0, f1, p0, p1;
            int          a, d, ek;
            logic        ee, g;
            v  = 2'($urandom_range(1, 3));
            c0 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            c1 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            f0 = $urandom;
            f1 = $urandom;
            p0 = $urandom;
            p1 = $urandom;
            a  = int'($urandom_range(0, 20));
            case ($urandom_range(0, 2))
                0:       d = a;
                1:       d = a + int'($urandom_range(1, 18));
                default: d = int'($urandom_range(0, 22));
            endcase
            g  = (v == 2'b11) ? ~last_gid : v[1];
            cw = g ? c1 : c0;
            model(cw, a, d, ek, ee);
            run_txn(v, c0, c1, f0, f1, p0, p1, a, d, g, ek, ee);
            last_gid = g;
        end

        req_valid = 2'b00;
        @(negedge CLK);
        check("final_busy", 64'(busy), 64'(1'b0));
        check("final_ready", 64'(req_ready), 64'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
